pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. Produces the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Produces the flush/new_pc pair for exception redirect.
- Owns the start/cancel handshake of the multi-cycle divider, so ID/EX holds a divide in EX until the result is ready.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall patterns, FSM state codes
// and control levels used by the core's pipeline registers.
package pipe_ctrl_pkg;

  localparam logic        STOP         = 1'b1;
  localparam logic        NO_STOP      = 1'b0;
  localparam logic        ENABLE       = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam logic [5:0]  STALL_NONE   = 6'b000000;
  localparam logic [5:0]  STALL_ID     = 6'b000111;
  localparam logic [5:0]  STALL_EX     = 6'b001111;
  localparam logic [5:0]  STALL_MEM    = 6'b011111;

  localparam logic [0:0]  CTRL_IDLE     = 1'b0;
  localparam logic [0:0]  CTRL_DIV_BUSY = 1'b1;

  localparam logic        DIV_START    = 1'b1;
  localparam logic        DIV_CANCEL   = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard requests, divider handshake, exception redirect and
// stall/flush outputs between the sequencer and the rest of the core.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              div_req;
  logic              div_ready;
  logic              excp_valid;
  logic [31:0]       excp_addr;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              div_start;
  logic              div_cancel;
  logic              div_err;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    input  stallreq_id, stallreq_ex, stallreq_mem, div_req, div_ready,
           excp_valid, excp_addr,
    output stall, flush, new_pc, div_start, div_cancel, div_err, stall_cycles
  );

  modport slave (
    output stallreq_id, stallreq_ex, stallreq_mem, div_req, div_ready,
           excp_valid, excp_addr,
    input  stall, flush, new_pc, div_start, div_cancel, div_err, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module pipe_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= sat_inc(q);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, exception flush/redirect, multi-cycle
// divider start/cancel handshake with timeout, and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_MAX_CYCLES = 40,
  parameter int CNT_W          = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.master bus
);

  localparam int BW = $clog2(DIV_MAX_CYCLES) + 1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [BW-1:0] busy_cnt;
  logic          err_set;
  logic          div_pending;
  logic [5:0]    stall_c;
  logic          flush_c;
  logic [31:0]   new_pc_c;
  logic          div_start_c;
  logic          div_cancel_c;
  logic          div_err_r;

  // Combinational outputs are forced quiet while rst is high.
  always_comb begin
    state_nxt    = state;
    div_pending  = 1'b0;
    div_start_c  = 1'b0;
    div_cancel_c = 1'b0;
    err_set      = 1'b0;
    stall_c      = STALL_NONE;
    flush_c      = 1'b0;
    new_pc_c     = ZERO_WORD;

    if (!rst) begin
      case (state)
        CTRL_IDLE: begin
          if (bus.div_req && !bus.excp_valid) begin
            div_start_c = DIV_START;
            div_pending = 1'b1;
            state_nxt   = CTRL_DIV_BUSY;
          end
        end
        CTRL_DIV_BUSY: begin
          state_nxt = CTRL_IDLE;
          // Flush beats a same-cycle result; result wins over timeout.
          if (bus.excp_valid) begin
            div_cancel_c = DIV_CANCEL;
          end else if (bus.div_ready) begin
            div_cancel_c = 1'b0;
          end else if (!bus.div_req) begin
            div_cancel_c = DIV_CANCEL;
          end else if (busy_cnt == BW'(DIV_MAX_CYCLES - 1)) begin
            div_cancel_c = DIV_CANCEL;
            err_set      = 1'b1;
          end else begin
            div_pending = 1'b1;
            state_nxt   = CTRL_DIV_BUSY;
          end
        end
        default: state_nxt = CTRL_IDLE;
      endcase

      if (bus.excp_valid) begin
        flush_c  = 1'b1;
        new_pc_c = bus.excp_addr;
      end else if (bus.stallreq_mem) begin
        stall_c = STALL_MEM;
      end else if (bus.stallreq_ex || div_pending) begin
        stall_c = STALL_EX;
      end else if (bus.stallreq_id) begin
        stall_c = STALL_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CTRL_IDLE;
      busy_cnt  <= '0;
      div_err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CTRL_IDLE)
        busy_cnt <= '0;
      else
        busy_cnt <= busy_cnt + BW'(1);
      if (err_set)
        div_err_r <= 1'b1;
    end
  end

  pipe_ctrl_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (stall_c[2] == STOP),
    .q   (bus.stall_cycles)
  );

  assign bus.stall      = stall_c;
  assign bus.flush      = flush_c;
  assign bus.new_pc     = new_pc_c;
  assign bus.div_start  = div_start_c;
  assign bus.div_cancel = div_cancel_c;
  assign bus.div_err    = div_err_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a short-timeout,
// narrow-counter instance fed the same requests.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_ctrl_if #(.CNT_W(32)) bm ();
  pipe_ctrl_if #(.CNT_W(3))  bt ();

  assign bt.stallreq_id  = bm.stallreq_id;
  assign bt.stallreq_ex  = bm.stallreq_ex;
  assign bt.stallreq_mem = bm.stallreq_mem;
  assign bt.div_req      = bm.div_req;
  assign bt.div_ready    = bm.div_ready;
  assign bt.excp_valid   = bm.excp_valid;
  assign bt.excp_addr    = bm.excp_addr;

  pipe_ctrl #(.DIV_MAX_CYCLES(40), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  pipe_ctrl #(.DIV_MAX_CYCLES(4), .CNT_W(3)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_in();
    bm.stallreq_id  = 1'b0;
    bm.stallreq_ex  = 1'b0;
    bm.stallreq_mem = 1'b0;
    bm.div_req      = 1'b0;
    bm.div_ready    = 1'b0;
    bm.excp_valid   = 1'b0;
    bm.excp_addr    = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset with every request asserted
    rst             = 1'b1;
    bm.stallreq_id  = 1'b1;
    bm.stallreq_ex  = 1'b1;
    bm.stallreq_mem = 1'b1;
    bm.div_req      = 1'b1;
    bm.div_ready    = 1'b1;
    bm.excp_valid   = 1'b1;
    bm.excp_addr    = 32'hdead_beef;
    step();
    step();
    settle();
    check_val("rst_stall",      32'(bm.stall), 32'h0);
    check_val("rst_flush",      32'(bm.flush), 32'h0);
    check_val("rst_new_pc",     bm.new_pc, 32'h0);
    check_val("rst_div_start",  32'(bm.div_start), 32'h0);
    check_val("rst_div_cancel", 32'(bm.div_cancel), 32'h0);
    check_val("rst_div_err",    32'(bm.div_err), 32'h0);
    check_val("rst_stall_cyc",  bm.stall_cycles, 32'h0);
    rst = 1'b0;
    clr_in();
    step();
    settle();
    check_val("idle_stall_cyc", bm.stall_cycles, 32'h0);

    // ID hazard for three cycles
    for (int i = 0; i < 3; i++) begin
      bm.stallreq_id = 1'b1;
      settle();
      check_val($sformatf("id_stall_%0d", i), 32'(bm.stall), 32'h07);
      step();
    end
    bm.stallreq_id = 1'b0;
    settle();
    check_val("id_stall_cyc", bm.stall_cycles, 32'd3);
    check_val("id_release", 32'(bm.stall), 32'h00);

    // Divide interrupted by an exception in its fourth cycle
    bm.div_req = 1'b1;
    settle();
    check_val("exd_start0", 32'(bm.div_start), 32'h1);
    check_val("exd_stall0", 32'(bm.stall), 32'h0f);
    step();
    for (int c = 1; c < 3; c++) begin
      settle();
      check_val($sformatf("exd_start%0d", c), 32'(bm.div_start), 32'h0);
      check_val($sformatf("exd_stall%0d", c), 32'(bm.stall), 32'h0f);
      step();
    end
    bm.excp_valid = 1'b1;
    bm.excp_addr  = 32'h0000_0040;
    settle();
    check_val("exd_flush",  32'(bm.flush), 32'h1);
    check_val("exd_new_pc", bm.new_pc, 32'h40);
    check_val("exd_stall3", 32'(bm.stall), 32'h00);
    check_val("exd_cancel", 32'(bm.div_cancel), 32'h1);
    step();
    bm.excp_valid = 1'b0;
    bm.excp_addr  = 32'h0;
    settle();
    check_val("exd_idle_restart", 32'(bm.div_start), 32'h1);
    check_val("exd_idle_flush",   32'(bm.flush), 32'h0);
    step();
    bm.div_req = 1'b0;
    settle();
    check_val("abandon_cancel", 32'(bm.div_cancel), 32'h1);
    check_val("abandon_stall",  32'(bm.stall), 32'h00);
    step();
    settle();
    check_val("abandon_idle", 32'(bm.div_cancel), 32'h0);

    // Divide completing at cycle 5 with no other hazard
    bm.div_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_val($sformatf("div_start_c%0d", c), 32'(bm.div_start), (c == 0) ? 32'h1 : 32'h0);
      check_val($sformatf("div_stall_c%0d", c), 32'(bm.stall), 32'h0f);
      step();
    end
    bm.div_ready = 1'b1;
    settle();
    check_val("div_ready_stall",  32'(bm.stall), 32'h00);
    check_val("div_ready_cancel", 32'(bm.div_cancel), 32'h0);
    step();
    bm.div_ready = 1'b0;
    bm.div_req   = 1'b0;
    settle();
    check_val("div_done_cancel", 32'(bm.div_cancel), 32'h0);
    check_val("div_done_stall",  32'(bm.stall), 32'h00);
    step();

    // Result arrives while MEM is waiting and EX is requesting
    bm.div_req = 1'b1;
    step();
    bm.div_ready    = 1'b1;
    bm.stallreq_mem = 1'b1;
    bm.stallreq_ex  = 1'b1;
    settle();
    check_val("rdy_mem_stall", 32'(bm.stall), 32'h1f);
    bm.stallreq_mem = 1'b0;
    settle();
    check_val("rdy_ex_stall", 32'(bm.stall), 32'h0f);
    step();
    bm.div_ready   = 1'b0;
    bm.stallreq_ex = 1'b0;
    settle();
    check_val("rdy_next_start", 32'(bm.div_start), 32'h1);
    step();
    bm.div_req = 1'b0;
    settle();
    check_val("rdy_next_cancel", 32'(bm.div_cancel), 32'h1);
    check_val("main_div_err", 32'(bm.div_err), 32'h0);
    step();

    // Timeout on the DIV_MAX_CYCLES=4 instance
    do_reset();
    settle();
    check_val("to_err_after_rst", 32'(bt.div_err), 32'h0);
    bm.div_req = 1'b1;
    settle();
    check_val("to_start", 32'(bt.div_start), 32'h1);
    step();
    for (int c = 1; c < 4; c++) begin
      settle();
      check_val($sformatf("to_cancel_c%0d", c), 32'(bt.div_cancel), 32'h0);
      check_val($sformatf("to_stall_c%0d", c), 32'(bt.stall), 32'h0f);
      step();
    end
    settle();
    check_val("to_cancel",   32'(bt.div_cancel), 32'h1);
    check_val("to_released", 32'(bt.stall), 32'h00);
    check_val("to_err_pre",  32'(bt.div_err), 32'h0);
    step();
    settle();
    check_val("to_err_set",  32'(bt.div_err), 32'h1);
    check_val("to_restart",  32'(bt.div_start), 32'h1);
    step();
    bm.div_req = 1'b0;
    step();
    step();
    settle();
    check_val("to_err_sticky", 32'(bt.div_err), 32'h1);

    // Saturation of the 3-bit counter
    do_reset();
    bm.stallreq_id = 1'b1;
    for (int i = 0; i < 9; i++) step();
    bm.stallreq_id = 1'b0;
    settle();
    check_val("sat_narrow", 32'(bt.stall_cycles), 32'd7);
    check_val("sat_wide",   bm.stall_cycles, 32'd9);

    // Priority: MEM over ID, exception over everything
    bm.stallreq_mem = 1'b1;
    bm.stallreq_id  = 1'b1;
    bm.excp_addr    = 32'h1234_5678;
    settle();
    check_val("prio_mem",        32'(bm.stall), 32'h1f);
    check_val("prio_mem_new_pc", bm.new_pc, 32'h0);
    bm.excp_valid = 1'b1;
    settle();
    check_val("prio_excp_stall",  32'(bm.stall), 32'h00);
    check_val("prio_excp_flush",  32'(bm.flush), 32'h1);
    check_val("prio_excp_new_pc", bm.new_pc, 32'h1234_5678);
    step();
    clr_in();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
